rca4: RTL and testbench
=======================

// Module: rca4
// PURPOSE
//   4-bit ripple-carry adder/subtractor: the arithmetic slice of the 4-bit ALU.
//   Built as a chain of four 1-bit full adders.
//   The B operand is conditionally inverted for subtraction.
//   Result and carry are registered once, on the rising clock edge.
// PARAMETERS
//   none (width fixed at 4 bits)
// PORTS
//   clk   input   1  system clock, rising-edge active
//   rst   input   1  asynchronous, active-high reset
//   a     input   4  operand A (unsigned)
//   b     input   4  operand B (unsigned)
//   cin   input   1  carry-in when op=0; borrow-in when op=1
//   op    input   1  0 = add, 1 = subtract
//   sum   output  4  registered result bits [3:0]
//   cout  output  1  registered carry-out (op=1: 1 = no borrow)
// BEHAVIOUR
//   - One clock; rst is asynchronous and active-high.
//   - While rst=1: sum=4'b0000 and cout=0 immediately, independent of clk.
//   - Datapath is combinational. Stage i full adder:
//       s[i]   = a[i] ^ bx[i] ^ c[i]
//       c[i+1] = a[i]&bx[i] | a[i]&c[i] | bx[i]&c[i]
//   - bx = b ^ {4{op}}.
//   - c[0] = cin ^ op (op=1 makes the borrow-in an inverted carry-in).
//   - op=0: {cout,sum} = a + b + cin (5-bit unsigned result).
//   - op=1: sum = (a - b - cin) mod 16; cout = c[4] = 1 iff a >= b + cin.
//   - Latency: 1 cycle. Inputs sampled at rising edge N appear on sum/cout
//     after edge N; outputs hold until the next edge.
//   - No handshake: a new operation every cycle.
//   - No overflow flag. Wrap-around modulo 16 is the required result.
//     Sum and cout are updated by the same edge (never torn).
//   - rst asserted mid-stream: outputs clear at once.
//     First rising edge after rst deasserts loads the current inputs.
//   - op, a, b or cin changing between edges has no effect on outputs until the next edge.
//   - X/Z on inputs is not handled; inputs must be driven from reset release.
// TESTING (check each result one cycle after applying inputs)
//   1) rst=1 with a=1111, b=1111, cin=1 -> sum=0000, cout=0 without a clock edge;
//      release rst -> next edge sum=1111, cout=1.
//   2) add: a=1111 b=0101 cin=0 -> sum=0100 cout=1;
//      a=0010 b=0010 cin=1 -> sum=0101 cout=0;
//      a=0100 b=0001 cin=1 -> sum=0110 cout=0.
//   3) sub: a=0101 b=0010 cin=0 -> sum=0011 cout=1;
//      a=1010 b=0110 cin=0 -> sum=0100 cout=1;
//      a=1110 b=0110 cin=0 -> sum=1000 cout=1.
//   4) sub with borrow / wrap:
//      a=0010 b=0011 cin=0 -> sum=1111 cout=0;
//      a=0010 b=0100 cin=0 -> sum=1110 cout=0;
//      a=0110 b=0110 cin=1 -> sum=1111 cout=0.
//   5) back-to-back ops changing every cycle (alternating op):
//      each result matches its own inputs with exactly 1-cycle latency.
//   6) exhaustive: all 2^10 combinations of a, b, cin, op vs a reference model;
//      assert rst mid-sequence -> outputs 0 at once, correct again 1 edge after release.

Source files
------------

// File: rtl/rca4_if.sv
// Operand/result bundle for the rca4 adder/subtractor slice.
// The master drives operands and control; the slave returns the registered result.
interface rca4_if;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic       op;
  logic [3:0] sum;
  logic       cout;

  modport master (
    output a,
    output b,
    output cin,
    output op,
    input  sum,
    input  cout
  );

  modport slave (
    input  a,
    input  b,
    input  cin,
    input  op,
    output sum,
    output cout
  );
endinterface

// File: rtl/rca4.sv
// 4-bit ripple-carry adder/subtractor with registered sum and carry-out.
// Subtraction inverts B and the borrow-in, so c[4]=1 means "no borrow".
module rca4 (
  input  logic  clk,
  input  logic  rst,
  rca4_if.slave bus
);

  logic [3:0] bx_s;
  logic [4:0] c_s;
  logic [3:0] s_s;
  logic [3:0] sum_r;
  logic       cout_r;

  // One full-adder stage; returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    logic s;
    logic co;
    s  = x ^ y ^ ci;
    co = (x & y) | (x & ci) | (y & ci);
    return {co, s};
  endfunction

  // Combinational ripple chain across the four stages.
  always_comb begin
    bx_s   = bus.b ^ {4{bus.op}};
    c_s    = 5'b00000;
    s_s    = 4'b0000;
    c_s[0] = bus.cin ^ bus.op;
    for (int i = 0; i < 4; i++) begin
      {c_s[i+1], s_s[i]} = full_add(bus.a[i], bx_s[i], c_s[i]);
    end
  end

  // Result register; sum and carry share the same edge so they are never torn.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_r  <= 4'b0000;
      cout_r <= 1'b0;
    end else begin
      sum_r  <= s_s;
      cout_r <= c_s[4];
    end
  end

  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;

endmodule

// File: tb/tb_rca4.sv
// Self-checking bench for rca4: directed tables, random back-to-back traffic,
// an exhaustive sweep with a mid-stream reset, all against an arithmetic model.
module tb_rca4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  rca4_if bus ();

  rca4 u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the documented add/subtract rules.
  function automatic logic [4:0] ref_model(input logic [3:0] a, input logic [3:0] b,
                                           input logic cin, input logic op);
    int r;
    int w;
    if (op == 1'b0) begin
      r = int'(a) + int'(b) + int'(cin);
      return r[4:0];
    end else begin
      r = int'(a) - int'(b) - int'(cin);
      w = (r + 32) % 16;
      return {(r >= 0), w[3:0]};
    end
  endfunction

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic cin, input logic op);
    @(negedge clk);
    bus.a   = a;
    bus.b   = b;
    bus.cin = cin;
    bus.op  = op;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst     = 1'b1;
    bus.a   = 4'b1111;
    bus.b   = 4'b1111;
    bus.cin = 1'b1;
    bus.op  = 1'b0;
    #2;
    checks++;
    if ({bus.cout, bus.sum} !== 5'b00000) begin
      failures++;
      $display("FAIL reset_hold got=%b expected=%b", {bus.cout, bus.sum}, 5'b00000);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.cout, bus.sum} !== 5'b11111) begin
      failures++;
      $display("FAIL reset_release got=%b expected=%b", {bus.cout, bus.sum}, 5'b11111);
    end
  endtask

  task automatic test_directed;
    logic [3:0] ta [9] = '{4'b1111, 4'b0010, 4'b0100, 4'b0101, 4'b1010, 4'b1110,
                           4'b0010, 4'b0010, 4'b0110};
    logic [3:0] tb [9] = '{4'b0101, 4'b0010, 4'b0001, 4'b0010, 4'b0110, 4'b0110,
                           4'b0011, 4'b0100, 4'b0110};
    logic       tc [9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       to [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [4:0] te [9] = '{5'b10100, 5'b00101, 5'b00110, 5'b10011, 5'b10100, 5'b11000,
                           5'b01111, 5'b01110, 5'b01111};
    for (int i = 0; i < 9; i++) begin
      drive(ta[i], tb[i], tc[i], to[i]);
      checks++;
      if ({bus.cout, bus.sum} !== te[i]) begin
        failures++;
        $display("FAIL directed[%0d] got=%b expected=%b", i, {bus.cout, bus.sum}, te[i]);
      end
      checks++;
      if (ref_model(ta[i], tb[i], tc[i], to[i]) !== te[i]) begin
        failures++;
        $display("FAIL model_table[%0d] got=%b expected=%b", i,
                 ref_model(ta[i], tb[i], tc[i], to[i]), te[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [4:0] exp;
    for (int i = 0; i < 40; i++) begin
      a   = 4'($urandom_range(0, 15));
      b   = 4'($urandom_range(0, 15));
      cin = 1'($urandom_range(0, 1));
      exp = ref_model(a, b, cin, 1'(i % 2));
      drive(a, b, cin, 1'(i % 2));
      checks++;
      if ({bus.cout, bus.sum} !== exp) begin
        failures++;
        $display("FAIL back_to_back[%0d] got=%b expected=%b", i, {bus.cout, bus.sum}, exp);
      end
    end
  endtask

  task automatic test_hold;
    logic [4:0] exp;
    for (int i = 0; i < 8; i++) begin
      drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      exp = ref_model(bus.a, bus.b, bus.cin, bus.op);
      #2;
      bus.a   = ~bus.a;
      bus.b   = bus.b + 4'd3;
      bus.cin = ~bus.cin;
      bus.op  = ~bus.op;
      #2;
      checks++;
      if ({bus.cout, bus.sum} !== exp) begin
        failures++;
        $display("FAIL hold[%0d] got=%b expected=%b", i, {bus.cout, bus.sum}, exp);
      end
    end
  endtask

  task automatic test_exhaustive;
    logic [9:0] v;
    logic [4:0] exp;
    for (int i = 0; i < 1024; i++) begin
      v   = 10'(i);
      exp = ref_model(v[3:0], v[7:4], v[8], v[9]);
      if (i == 512) begin
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.cout, bus.sum} !== 5'b00000) begin
          failures++;
          $display("FAIL midstream_reset got=%b expected=%b", {bus.cout, bus.sum}, 5'b00000);
        end
        bus.a   = v[3:0];
        bus.b   = v[7:4];
        bus.cin = v[8];
        bus.op  = v[9];
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
      end else begin
        drive(v[3:0], v[7:4], v[8], v[9]);
      end
      checks++;
      if ({bus.cout, bus.sum} !== exp) begin
        failures++;
        $display("FAIL exhaustive[%0d] got=%b expected=%b", i, {bus.cout, bus.sum}, exp);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_hold();
    test_exhaustive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
